// File: rtl/ascon_perm_ctrl.sv
// Round controller and state register that iterates the external Ascon-p core.
// Optional S-box LUT reprogramming path is enabled with `define ASCON_SBOX_UPD_EN.
module ascon_perm_ctrl #(
  parameter int UROL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  rounds_i,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o,
  output logic        busy_o,
`ifdef ASCON_SBOX_UPD_EN
  input  logic        cfg_upd_i,
  input  logic [4:0]  cfg_addr_i,
  input  logic [19:0] cfg_data_i,
  output logic        cfg_ready_o,
  output logic        perm_upd_sbox_o,
  output logic [4:0]  perm_sbox_addr_o,
  output logic [19:0] perm_sbox_data_o,
`endif
  output logic [3:0]  perm_round_cnt_o,
  output logic [63:0] perm_x0_o,
  output logic [63:0] perm_x1_o,
  output logic [63:0] perm_x2_o,
  output logic [63:0] perm_x3_o,
  output logic [63:0] perm_x4_o,
  input  logic [63:0] perm_x0_i,
  input  logic [63:0] perm_x1_i,
  input  logic [63:0] perm_x2_i,
  input  logic [63:0] perm_x3_i,
  input  logic [63:0] perm_x4_i
);

  localparam logic [3:0] UROL4 = 4'(UROL);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            r_fsm;
  logic [3:0]        r_rcnt;
  logic [4:0][63:0]  r_x;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic [4:0][63:0]  w_in;
  logic [4:0][63:0]  w_perm;
  logic [3:0]        w_clamp;
  logic [3:0]        w_rounds;
  logic [3:0]        w_rcnt_nx;
  logic              w_last;

  assign w_in   = {x4_i, x3_i, x2_i, x1_i, x0_i};
  assign w_perm = {perm_x4_i, perm_x3_i, perm_x2_i, perm_x1_i, perm_x0_i};

  // Round count is clamped to 12 and rounded up to whole core steps; the
  // rounds always finish at index 11 so the core sees the p12 tail constants.
  assign w_clamp   = (rounds_i > 4'd12) ? 4'd12 : rounds_i;
  assign w_rounds  = w_clamp + ((UROL4 - (w_clamp % UROL4)) % UROL4);
  assign w_rcnt_nx = r_rcnt + UROL4;
  assign w_last    = (w_rcnt_nx == 4'd12);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_rcnt      <= 4'd0;
      r_x         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid_i) begin
            r_x        <= w_in;
            r_rcnt     <= 4'd12 - w_rounds;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_rounds == 4'd0) begin
              r_fsm       <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_fsm <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r_x    <= w_perm;
          r_rcnt <= w_rcnt_nx;
          if (w_last) begin
            r_fsm       <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            r_fsm       <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o       = r_in_ready;
  assign out_valid_o      = r_out_valid;
  assign busy_o           = r_busy;
  assign perm_round_cnt_o = r_rcnt;
  assign {x4_o, x3_o, x2_o, x1_o, x0_o} = r_x;
  assign {perm_x4_o, perm_x3_o, perm_x2_o, perm_x1_o, perm_x0_o} = r_x;

`ifdef ASCON_SBOX_UPD_EN
  // A pending input takes priority over a LUT write in the same cycle.
  assign cfg_ready_o      = (r_fsm == S_IDLE) && !in_valid_i;
  assign perm_upd_sbox_o  = cfg_upd_i && cfg_ready_o;
  assign perm_sbox_addr_o = cfg_addr_i;
  assign perm_sbox_data_o = cfg_data_i;
`endif

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: a behavioural Ascon-p core closes the loop and a
// whole-permutation reference model supplies expected results and latencies.
module tb_ascon_perm_ctrl;

  typedef logic [4:0][63:0] st_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  rounds, perm_round_cnt;
  st_t         in_st, out_st, core_in, core_out;
  logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
  logic [63:0] px0_o, px1_o, px2_o, px3_o, px4_o;
  logic [63:0] px0_i, px1_i, px2_i, px3_i, px4_i;
`ifdef ASCON_SBOX_UPD_EN
  logic        cfg_upd, cfg_ready, perm_upd;
  logic [4:0]  cfg_addr, perm_addr;
  logic [19:0] cfg_data, perm_data;
`endif

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ascon_perm_ctrl #(.UROL(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .rounds_i(rounds),
    .x0_i(in_st[0]), .x1_i(in_st[1]), .x2_i(in_st[2]), .x3_i(in_st[3]), .x4_i(in_st[4]),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .x0_o(x0_o), .x1_o(x1_o), .x2_o(x2_o), .x3_o(x3_o), .x4_o(x4_o),
    .busy_o(busy),
`ifdef ASCON_SBOX_UPD_EN
    .cfg_upd_i(cfg_upd), .cfg_addr_i(cfg_addr), .cfg_data_i(cfg_data), .cfg_ready_o(cfg_ready),
    .perm_upd_sbox_o(perm_upd), .perm_sbox_addr_o(perm_addr), .perm_sbox_data_o(perm_data),
`endif
    .perm_round_cnt_o(perm_round_cnt),
    .perm_x0_o(px0_o), .perm_x1_o(px1_o), .perm_x2_o(px2_o), .perm_x3_o(px3_o), .perm_x4_o(px4_o),
    .perm_x0_i(px0_i), .perm_x1_i(px1_i), .perm_x2_i(px2_i), .perm_x3_i(px3_i), .perm_x4_i(px4_i)
  );

  function automatic logic [63:0] ror(logic [63:0] v, int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One Ascon-p round with p12 round index r (constant ((15-r)<<4)|r).
  function automatic st_t ascon_round(st_t s, logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [3:0]  rc_hi;
    rc_hi = 4'd15 - r;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 = x2 ^ {56'd0, rc_hi, r};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic st_t permute(st_t s, int nr);
    st_t t;
    t = s;
    for (int i = 12 - nr; i < 12; i++) t = ascon_round(t, 4'(i));
    return t;
  endfunction

  function automatic st_t rand_state();
    st_t t;
    for (int i = 0; i < 5; i++) t[i] = {$urandom, $urandom};
    return t;
  endfunction

  // Behavioural core: one round per cycle at the index the controller presents.
  assign core_in = {px4_o, px3_o, px2_o, px1_o, px0_o};
  always_comb core_out = ascon_round(core_in, perm_round_cnt);
  assign {px4_i, px3_i, px2_i, px1_i, px0_i} = core_out;
  assign out_st = {x4_o, x3_o, x2_o, x1_o, x0_o};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag, input st_t exp);
    for (int i = 0; i < 5; i++) check($sformatf("%s_x%0d", tag, i), out_st[i], exp[i]);
  endtask

  // One transaction; abort_at>0 pulses reset in that RUN cycle instead of finishing.
  task automatic run_txn(input logic [3:0] rnd, input st_t st, input int hold, input int abort_at);
    int  nr;
    st_t exp;
    nr  = (rnd > 4'd12) ? 12 : int'(rnd);
    exp = permute(st, nr);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b1);
`ifdef ASCON_SBOX_UPD_EN
    cfg_upd = 1'b1; cfg_addr = 5'd3; cfg_data = 20'(($urandom));
    #1;
    check("cfg_idle_fwd", perm_upd, 1'b1);
    check("cfg_idle_addr", perm_addr, 5'd3);
    check("cfg_idle_data", perm_data, cfg_data);
`endif
    in_valid = 1'b1; rounds = rnd; in_st = st;
`ifdef ASCON_SBOX_UPD_EN
    #1;
    check("cfg_accept_held", cfg_ready, 1'b0);
    check("cfg_accept_fwd", perm_upd, 1'b0);
`endif
    @(negedge clk);
    for (int c = 1; c <= nr; c++) begin
      check($sformatf("run%0d_out_valid", c), out_valid, 1'b0);
      check($sformatf("run%0d_busy", c), busy, 1'b1);
      check($sformatf("run%0d_round_cnt", c), perm_round_cnt, 64'(12 - nr + c - 1));
`ifdef ASCON_SBOX_UPD_EN
      check("cfg_run_ready", cfg_ready, 1'b0);
      check("cfg_run_fwd", perm_upd, 1'b0);
`endif
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_round_cnt", perm_round_cnt, 4'd0);
        check_state("abort", '0);
        check("abort_perm_x0", px0_o, 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_release_in_ready", in_ready, 1'b1);
        check("abort_release_out_valid", out_valid, 1'b0);
        $display("txn rounds=%0d aborted in run cycle %0d", rnd, c);
        return;
      end
      in_valid = 1'($urandom_range(0, 1));
      in_st = rand_state();
      rounds = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
`ifdef ASCON_SBOX_UPD_EN
    cfg_upd = 1'b0;
`endif
    check("done_out_valid", out_valid, 1'b1);
    check("done_busy", busy, 1'b1);
    check("done_in_ready", in_ready, 1'b0);
    check_state("done", exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; in_st = rand_state();
      @(negedge clk);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check_state("hold", exp);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
    check("post_busy", busy, 1'b0);
    $display("txn rounds=%0d effective=%0d hold=%0d x0=%h", rnd, nr, hold, exp[0]);
  endtask

  initial begin
    st_t s;
    in_valid = 1'b0; out_ready = 1'b0; rounds = 4'd0; in_st = '0;
`ifdef ASCON_SBOX_UPD_EN
    cfg_upd = 1'b0; cfg_addr = 5'd0; cfg_data = 20'd0;
`endif
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_round_cnt", perm_round_cnt, 4'd0);
    check("rst_x0", x0_o, 64'd0);
    check("rst_perm_x4", px4_o, 64'd0);
    rst_n = 1'b1;

    run_txn(4'd12, '0, 0, 0);
    run_txn(4'd6, rand_state(), 0, 0);
    s = '0; s[0] = 64'h0123456789abcdef;
    run_txn(4'd0, s, 0, 0);
    run_txn(4'd3, rand_state(), 5, 0);
    run_txn(4'd15, rand_state(), 1, 0);
    run_txn(4'd12, rand_state(), 0, 5);
    for (int t = 0; t < 8; t++)
      run_txn(4'($urandom_range(0, 15)), rand_state(), int'($urandom_range(0, 3)), 0);
    run_txn(4'd1, rand_state(), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
